// File: rtl/multi_cycle_control_unit_if.sv
// Control/status bundle between the multi-cycle control unit (master) and the
// RV32I datapath (slave).
interface multi_cycle_control_unit_if;
    logic [6:0] opcode;
    logic       bcond;
    logic       halt_req;
    logic       mem_ready;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       alu_out_write;
    logic       pc_source;
    logic       is_halted;

    modport master (
        input  opcode, bcond, halt_req, mem_ready,
        output pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, alu_out_write,
               pc_source, is_halted
    );

    modport slave (
        output opcode, bcond, halt_req, mem_ready,
        input  pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, alu_out_write,
               pc_source, is_halted
    );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// Sequencer for the multi-cycle RV32I datapath: one micro-step per clock,
// stalls on mem_ready for fetch/load/store, halts on qualified ECALL.
module multi_cycle_control_unit (
    input logic                         clk,
    input logic                         reset_n,
    multi_cycle_control_unit_if.master  bus
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    localparam logic [3:0] S_IF      = 4'd0;
    localparam logic [3:0] S_ID      = 4'd1;
    localparam logic [3:0] S_PC_INC  = 4'd2;
    localparam logic [3:0] S_EX_ALU  = 4'd3;
    localparam logic [3:0] S_WB_ALU  = 4'd4;
    localparam logic [3:0] S_EX_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_LD  = 4'd6;
    localparam logic [3:0] S_WB_LD   = 4'd7;
    localparam logic [3:0] S_MEM_ST  = 4'd8;
    localparam logic [3:0] S_EX_BR   = 4'd9;
    localparam logic [3:0] S_BR_TAKE = 4'd10;
    localparam logic [3:0] S_EX_J    = 4'd11;
    localparam logic [3:0] S_EX_JR   = 4'd12;
    localparam logic [3:0] S_HALT    = 4'd13;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_BR    = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    logic [3:0] state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IF;
        else          state_q <= state_d;
    end

    // Outputs are forced low combinationally while reset is asserted, since
    // the reset state (IF) would otherwise raise mem_read immediately.
    always_comb begin
        state_d           = state_q;
        bus.pc_write      = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.alu_op        = ALU_ADD;
        bus.alu_out_write = 1'b0;
        bus.pc_source     = 1'b0;
        bus.is_halted     = 1'b0;
        if (reset_n) begin
            case (state_q)
                S_IF: begin
                    bus.mem_read = 1'b1;
                    bus.ir_write = bus.mem_ready;
                    if (bus.mem_ready) state_d = S_ID;
                end
                S_ID: begin
                    bus.alu_src_b     = 2'd1;
                    bus.alu_out_write = 1'b1;
                    case (bus.opcode)
                        OP_R, OP_I:    state_d = S_EX_ALU;
                        OP_LD, OP_ST:  state_d = S_EX_ADDR;
                        OP_BR:         state_d = S_EX_BR;
                        OP_JAL:        state_d = S_EX_J;
                        OP_JALR:       state_d = S_EX_JR;
                        OP_SYS:        state_d = bus.halt_req ? S_HALT : S_PC_INC;
                        default:       state_d = S_PC_INC;
                    endcase
                end
                S_PC_INC: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 1'b1;
                    state_d       = S_IF;
                end
                S_EX_ALU: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_src_b     = (bus.opcode == OP_I) ? 2'd2 : 2'd0;
                    bus.alu_op        = ALU_FUNCT;
                    bus.alu_out_write = 1'b1;
                    state_d           = S_WB_ALU;
                end
                S_WB_ALU, S_WB_LD: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = (state_q == S_WB_LD);
                    bus.alu_src_b  = 2'd1;
                    bus.pc_write   = 1'b1;
                    state_d        = S_IF;
                end
                S_EX_ADDR: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_src_b     = 2'd2;
                    bus.alu_out_write = 1'b1;
                    state_d           = (bus.opcode == OP_ST) ? S_MEM_ST : S_MEM_LD;
                end
                S_MEM_LD: begin
                    bus.i_or_d   = 1'b1;
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) state_d = S_WB_LD;
                end
                S_MEM_ST: begin
                    // PC+4 selects are held for the whole wait; only the write strobes on ready
                    bus.i_or_d    = 1'b1;
                    bus.mem_write = 1'b1;
                    bus.alu_src_b = 2'd1;
                    bus.pc_write  = bus.mem_ready;
                    if (bus.mem_ready) state_d = S_IF;
                end
                S_EX_BR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALU_BR;
                    bus.pc_write  = ~bus.bcond;
                    bus.pc_source = ~bus.bcond;
                    state_d       = bus.bcond ? S_BR_TAKE : S_IF;
                end
                S_BR_TAKE: begin
                    bus.alu_src_b = 2'd2;
                    bus.pc_write  = 1'b1;
                    state_d       = S_IF;
                end
                S_EX_J, S_EX_JR: begin
                    bus.reg_write = 1'b1;
                    bus.alu_src_a = (state_q == S_EX_JR);
                    bus.alu_src_b = 2'd2;
                    bus.pc_write  = 1'b1;
                    state_d       = S_IF;
                end
                S_HALT: begin
                    bus.is_halted = 1'b1;
                end
                default: state_d = S_IF;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: directed latency table, corner-case
// sequences and randomized instructions checked against a micro-step model.
module tb_multi_cycle_control_unit;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    typedef struct packed {
        logic pcw, iord, mr, mw, irw, m2r, rw, sa;
        logic [1:0] sb, op;
        logic aow, ps, hlt;
    } ctl_t;

    typedef enum int {T_F, T_D, T_NOP, T_EXR, T_EXI, T_WB, T_ADDR, T_LD, T_WBLD,
                      T_ST, T_BR, T_BRT, T_JAL, T_JALR, T_HALT} step_e;

    typedef struct {
        logic [6:0] op;
        logic hr, bc;
        int cyc, nrw, npw, nmr, nmw;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    multi_cycle_control_unit_if bus();
    multi_cycle_control_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;

    ctl_t obs;
    assign obs = {bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                  bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.alu_out_write, bus.pc_source, bus.is_halted};

    int n_pass = 0, n_chk = 0;
    int r_cyc, r_rw, r_pw, r_mr, r_mw, r_irw;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected control word for one micro-step, straight from the step descriptions.
    function automatic ctl_t model(step_e s, logic rdy, logic bc);
        ctl_t c = '0;
        case (s)
            T_F:    begin c.mr = 1; c.irw = rdy; end
            T_D:    begin c.sb = 2'd1; c.aow = 1; end
            T_NOP:  begin c.pcw = 1; c.ps = 1; end
            T_EXR:  begin c.sa = 1; c.op = 2'd2; c.aow = 1; end
            T_EXI:  begin c.sa = 1; c.sb = 2'd2; c.op = 2'd2; c.aow = 1; end
            T_WB:   begin c.rw = 1; c.sb = 2'd1; c.pcw = 1; end
            T_WBLD: begin c.rw = 1; c.m2r = 1; c.sb = 2'd1; c.pcw = 1; end
            T_ADDR: begin c.sa = 1; c.sb = 2'd2; c.aow = 1; end
            T_LD:   begin c.iord = 1; c.mr = 1; end
            T_ST:   begin c.iord = 1; c.mw = 1; c.sb = 2'd1; c.pcw = rdy; end
            T_BR:   begin c.sa = 1; c.op = 2'd1; c.pcw = ~bc; c.ps = ~bc; end
            T_BRT:  begin c.sb = 2'd2; c.pcw = 1; end
            T_JAL:  begin c.rw = 1; c.sb = 2'd2; c.pcw = 1; end
            T_JALR: begin c.rw = 1; c.sa = 1; c.sb = 2'd2; c.pcw = 1; end
            T_HALT: begin c.hlt = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Runs one instruction from its fetch; stalls<0 means random mem_ready.
    // Starts and ends 1 time unit after a rising edge.
    task automatic run_instr(input logic [6:0] op, input logic hr, input logic bc, input int stalls);
        step_e q[$];
        int waited;
        bit done;
        logic rdy;
        ctl_t exp;
        q.push_back(T_F);
        q.push_back(T_D);
        case (op)
            OP_R:    begin q.push_back(T_EXR); q.push_back(T_WB); end
            OP_I:    begin q.push_back(T_EXI); q.push_back(T_WB); end
            OP_LD:   begin q.push_back(T_ADDR); q.push_back(T_LD); q.push_back(T_WBLD); end
            OP_ST:   begin q.push_back(T_ADDR); q.push_back(T_ST); end
            OP_BR:   begin q.push_back(T_BR); if (bc) q.push_back(T_BRT); end
            OP_JAL:  q.push_back(T_JAL);
            OP_JALR: q.push_back(T_JALR);
            OP_SYS:  q.push_back(hr ? T_HALT : T_NOP);
            default: q.push_back(T_NOP);
        endcase
        r_cyc = 0; r_rw = 0; r_pw = 0; r_mr = 0; r_mw = 0; r_irw = 0;
        bus.opcode = op; bus.halt_req = hr; bus.bcond = bc;
        for (int i = 0; i < q.size(); i++) begin
            waited = 0;
            done = 0;
            while (!done) begin
                if (stalls < 0) rdy = (waited > 20) || ($urandom_range(0, 2) != 0);
                else            rdy = (waited >= stalls);
                bus.mem_ready = rdy;
                @(negedge clk);
                exp = model(q[i], rdy, bc);
                chk($sformatf("op%b step%0d wait%0d", op, i, waited), 32'(obs), 32'(exp));
                r_cyc++;
                r_rw += int'(obs.rw); r_pw += int'(obs.pcw); r_mr += int'(obs.mr);
                r_mw += int'(obs.mw); r_irw += int'(obs.irw);
                if (q[i] == T_HALT) done = (waited >= 19);
                else done = !(q[i] inside {T_F, T_LD, T_ST}) || rdy;
                waited++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.mem_ready = 1'b0; bus.opcode = '0; bus.bcond = 1'b0; bus.halt_req = 1'b0;
        #1;
        chk("reset outputs zero", 32'(obs), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0] = '{OP_R,    1'b0, 1'b0, 4, 1, 1, 1, 0};
        tbl[1] = '{OP_I,    1'b0, 1'b0, 4, 1, 1, 1, 0};
        tbl[2] = '{OP_LD,   1'b0, 1'b0, 5, 1, 1, 2, 0};
        tbl[3] = '{OP_ST,   1'b0, 1'b0, 4, 0, 1, 1, 1};
        tbl[4] = '{OP_BR,   1'b0, 1'b0, 3, 0, 1, 1, 0};
        tbl[5] = '{OP_BR,   1'b0, 1'b1, 4, 0, 1, 1, 0};
        tbl[6] = '{OP_JAL,  1'b0, 1'b0, 3, 1, 1, 1, 0};
        tbl[7] = '{OP_JALR, 1'b0, 1'b0, 3, 1, 1, 1, 0};
        tbl[8] = '{OP_SYS,  1'b0, 1'b0, 3, 0, 1, 1, 0};
        tbl[9] = '{7'b0000000, 1'b0, 1'b0, 3, 0, 1, 1, 0};

        do_reset();

        foreach (tbl[k]) begin
            run_instr(tbl[k].op, tbl[k].hr, tbl[k].bc, 0);
            chk($sformatf("tbl%0d cycles", k), r_cyc, tbl[k].cyc);
            chk($sformatf("tbl%0d reg_write", k), r_rw, tbl[k].nrw);
            chk($sformatf("tbl%0d pc_write", k), r_pw, tbl[k].npw);
            chk($sformatf("tbl%0d mem_read", k), r_mr, tbl[k].nmr);
            chk($sformatf("tbl%0d mem_write", k), r_mw, tbl[k].nmw);
            chk($sformatf("tbl%0d ir_write", k), r_irw, 1);
        end

        // LW with 2-cycle stalls in fetch and load
        run_instr(OP_LD, 1'b0, 1'b0, 2);
        chk("lw stall cycles", r_cyc, 9);
        chk("lw stall ir_write", r_irw, 1);
        chk("lw stall reg_write", r_rw, 1);

        // SW with 3-cycle stalls
        run_instr(OP_ST, 1'b0, 1'b0, 3);
        chk("sw stall cycles", r_cyc, 10);
        chk("sw stall mem_write", r_mw, 4);
        chk("sw stall pc_write", r_pw, 1);
        chk("sw stall reg_write", r_rw, 0);

        // ECALL with halt: HALT held for 20 cycles
        run_instr(OP_SYS, 1'b1, 1'b0, 0);
        chk("halt cycles", r_cyc, 22);
        chk("halt pc_write", r_pw, 0);
        chk("halt reg_write", r_rw, 0);
        do_reset();
        run_instr(OP_SYS, 1'b0, 1'b0, 0);
        chk("ecall nohalt pc_write", r_pw, 1);

        // Reset asserted mid load-wait takes effect without a clock edge
        bus.opcode = OP_LD; bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("mem_ld wait", 32'(obs), 32'(model(T_LD, 1'b0, 1'b0)));
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("async reset outputs", 32'(obs), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("after reset fetch", 32'(obs), 32'(model(T_F, 1'b0, 1'b0)));
        @(posedge clk); #1;

        // Randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            logic [6:0] ops[11];
            logic [6:0] op;
            logic hr;
            ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_SYS,
                    7'b0000000, 7'b1111111, 7'b0010111};
            op = ops[$urandom_range(0, 10)];
            hr = ($urandom_range(0, 3) == 0);
            run_instr(op, hr, 1'($urandom_range(0, 1)), -1);
            if (op == OP_SYS && hr) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
